// File: rtl/mem_arbiter_if.sv
// Request, completion and memory-macro signals shared by the CPU controller, the DMA/loader
// port and the unified memory. The slave modport is the arbiter's view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_stall,
    output dma_rdata, dma_ack,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_stall,
    input  dma_rdata, dma_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serializes CPU and DMA accesses onto one fixed-latency synchronous memory. CPU has priority;
// a bounded run of CPU grants while DMA waits forces the next grant to DMA.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_LIM = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int unsigned LatW    = $clog2(MEM_LAT + 1);
  localparam int unsigned StarveW = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;
  typedef enum logic {OwnCpu, OwnDma} owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [LatW-1:0]     lat_cnt_q, lat_cnt_d;
  logic [StarveW-1:0]  starve_cnt_q, starve_cnt_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;

  logic any_req;
  logic starved;
  logic grant_dma;

  assign any_req   = bus.cpu_req | bus.dma_req;
  assign starved   = (starve_cnt_q == StarveW'(STARVE_LIM));
  assign grant_dma = bus.dma_req & (~bus.cpu_req | starved);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StIssue;
          if (grant_dma) begin
            owner_d      = OwnDma;
            we_d         = bus.dma_we;
            addr_d       = bus.dma_addr;
            wdata_d      = bus.dma_wdata;
            starve_cnt_d = '0;
          end else begin
            owner_d = OwnCpu;
            we_d    = bus.cpu_we;
            addr_d  = bus.cpu_addr;
            wdata_d = bus.cpu_wdata;
            if (bus.dma_req && !starved) begin
              starve_cnt_d = starve_cnt_q + 1'b1;
            end
          end
        end
      end
      StIssue: begin
        if (we_q) begin
          state_d = StDone;
        end else begin
          state_d   = StWait;
          lat_cnt_d = LatW'(1);
        end
      end
      StWait: begin
        if (lat_cnt_q == LatW'(MEM_LAT)) begin
          state_d = StDone;
          if (owner_q == OwnDma) begin
            dma_rdata_d = bus.mem_rdata;
          end else begin
            cpu_rdata_d = bus.mem_rdata;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A DMA port that is not asking cannot be starved.
    if (!bus.dma_req) begin
      starve_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= OwnCpu;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign bus.mem_en    = (state_q == StIssue);
  assign bus.mem_we    = (state_q == StIssue) & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.dma_ack   = (state_q == StDone) & (owner_q == OwnDma);
  assign bus.cpu_stall = bus.cpu_req & ~((state_q == StDone) & (owner_q == OwnCpu));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter at MEM_LAT=2 and MEM_LAT=1 against a
// transaction-level model of arbitration, access timing and memory contents.
module tb_mem_arbiter;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;
  localparam int LIM  = 4;

  logic        clk;
  logic        rst;
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  logic [31:0] gmem  [256];
  logic [31:0] mem0  [256];
  logic [31:0] mem1  [256];
  logic [31:0] pipe0 [LAT0];
  logic [31:0] pipe1 [LAT1];

  int unsigned n_pass, n_fail, n_total;

  logic        c, d, win_dma, t_we;
  logic [31:0] t_addr, t_wdata, exp_cpu, exp_dma;
  int          cnt_m, t_len;
  logic [9:0]  evt;
  int          ne, first_ack, acks, en_cnt;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT0), .STARVE_LIM(LIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT1), .STARVE_LIM(LIM)) dut_lat1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Both instances see the same requesters; each has its own memory macro.
  assign bus1.cpu_req   = bus0.cpu_req;
  assign bus1.cpu_we    = bus0.cpu_we;
  assign bus1.cpu_addr  = bus0.cpu_addr;
  assign bus1.cpu_wdata = bus0.cpu_wdata;
  assign bus1.dma_req   = bus0.dma_req;
  assign bus1.dma_we    = bus0.dma_we;
  assign bus1.dma_addr  = bus0.dma_addr;
  assign bus1.dma_wdata = bus0.dma_wdata;
  assign bus0.mem_rdata = pipe0[LAT0-1];
  assign bus1.mem_rdata = pipe1[LAT1-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory macros: read data valid MEM_LAT cycles after mem_en, poison otherwise.
  always @(posedge clk) begin
    if (pl_en) begin
      mem0[pl_addr] <= pl_data;
      mem1[pl_addr] <= pl_data;
    end
    if (bus0.mem_en && bus0.mem_we) mem0[bus0.mem_addr[7:0]] <= bus0.mem_wdata;
    if (bus1.mem_en && bus1.mem_we) mem1[bus1.mem_addr[7:0]] <= bus1.mem_wdata;
    pipe0[0] <= bus0.mem_en ? mem0[bus0.mem_addr[7:0]] : 32'h0BAD_0BAD;
    for (int i = 1; i < LAT0; i++) pipe0[i] <= pipe0[i-1];
    pipe1[0] <= bus1.mem_en ? mem1[bus1.mem_addr[7:0]] : 32'h0BAD_0BAD;
    for (int i = 1; i < LAT1; i++) pipe1[i] <= pipe1[i-1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus0.cpu_req = 1'b0;
    bus0.dma_req = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  always @(negedge clk) begin
    chk1("we_without_en_lat2", bus0.mem_we & ~bus0.mem_en, 1'b0);
    chk1("we_without_en_lat1", bus1.mem_we & ~bus1.mem_en, 1'b0);
  end

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    rst = 1'b1;
    pl_en = 1'b1; pl_addr = '0; pl_data = '0;
    bus0.cpu_req = 1'b0; bus0.cpu_we = 1'b0; bus0.cpu_addr = '0; bus0.cpu_wdata = '0;
    bus0.dma_req = 1'b0; bus0.dma_we = 1'b0; bus0.dma_addr = '0; bus0.dma_wdata = '0;

    // Preload both macros (and the model) while held in reset.
    for (int i = 0; i < 256; i++) begin
      pl_addr = 8'(i);
      pl_data = (i == 'h40) ? 32'h8C01_0004 : (i == 'h80) ? 32'hDEAD_BEEF : $urandom;
      gmem[i] = pl_data;
      tick();
    end
    pl_en = 1'b0;

    // Reset values
    bus0.cpu_req = 1'b1;
    smp();
    chk1("rst_mem_en", bus0.mem_en, 1'b0);
    chk1("rst_mem_we", bus0.mem_we, 1'b0);
    chk1("rst_dma_ack", bus0.dma_ack, 1'b0);
    chk("rst_mem_addr", bus0.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus0.mem_wdata, 32'h0);
    chk("rst_cpu_rdata", bus0.cpu_rdata, 32'h0);
    chk("rst_dma_rdata", bus0.dma_rdata, 32'h0);
    chk1("rst_stall_follows_req", bus0.cpu_stall, 1'b1);
    tick();
    rst = 1'b0;
    idle(2);

    // CPU read of 0x40, lat-2 and lat-1 instances side by side
    bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b0; bus0.cpu_addr = 32'h40;
    smp();
    chk1("rd_c0_stall", bus0.cpu_stall, 1'b1);
    chk1("rd_c0_en", bus0.mem_en, 1'b0);
    tick(); smp();
    chk1("rd_c1_en", bus0.mem_en, 1'b1);
    chk1("rd_c1_we", bus0.mem_we, 1'b0);
    chk("rd_c1_addr", bus0.mem_addr, 32'h40);
    chk1("rd_c1_stall", bus0.cpu_stall, 1'b1);
    chk1("l1_c1_en", bus1.mem_en, 1'b1);
    chk("l1_c1_addr", bus1.mem_addr, 32'h40);
    tick(); smp();
    chk1("rd_c2_en", bus0.mem_en, 1'b0);
    chk1("rd_c2_stall", bus0.cpu_stall, 1'b1);
    chk1("l1_c2_stall", bus1.cpu_stall, 1'b1);
    tick(); smp();
    chk1("rd_c3_stall", bus0.cpu_stall, 1'b1);
    chk("rd_c3_rdata_old", bus0.cpu_rdata, 32'h0);
    chk1("l1_c3_done", bus1.cpu_stall, 1'b0);
    chk("l1_c3_rdata", bus1.cpu_rdata, 32'h8C01_0004);
    tick(); smp();
    chk1("rd_c4_stall", bus0.cpu_stall, 1'b0);
    chk1("rd_c4_en", bus0.mem_en, 1'b0);
    chk("rd_c4_rdata", bus0.cpu_rdata, 32'h8C01_0004);
    tick();
    idle(8);

    // Simultaneous writes: CPU first, then DMA
    bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b1; bus0.cpu_addr = 32'h10; bus0.cpu_wdata = 32'h1111_2222;
    bus0.dma_req = 1'b1; bus0.dma_we = 1'b1; bus0.dma_addr = 32'h20; bus0.dma_wdata = 32'h3333_4444;
    gmem['h10] = 32'h1111_2222;
    gmem['h20] = 32'h3333_4444;
    smp();
    chk1("sim_c0_stall", bus0.cpu_stall, 1'b1);
    tick(); smp();
    chk1("sim_c1_en", bus0.mem_en, 1'b1);
    chk1("sim_c1_we", bus0.mem_we, 1'b1);
    chk("sim_c1_addr", bus0.mem_addr, 32'h10);
    chk("sim_c1_wdata", bus0.mem_wdata, 32'h1111_2222);
    tick(); smp();
    chk1("sim_c2_stall", bus0.cpu_stall, 1'b0);
    chk1("sim_c2_ack", bus0.dma_ack, 1'b0);
    tick();
    bus0.cpu_req = 1'b0;
    smp();
    chk1("sim_c3_en", bus0.mem_en, 1'b0);
    tick(); smp();
    chk1("sim_c4_en", bus0.mem_en, 1'b1);
    chk1("sim_c4_we", bus0.mem_we, 1'b1);
    chk("sim_c4_addr", bus0.mem_addr, 32'h20);
    chk("sim_c4_wdata", bus0.mem_wdata, 32'h3333_4444);
    chk1("sim_c4_ack", bus0.dma_ack, 1'b0);
    tick(); smp();
    chk1("sim_c5_ack", bus0.dma_ack, 1'b1);
    tick();
    bus0.dma_req = 1'b0;
    smp();
    chk1("sim_c6_ack", bus0.dma_ack, 1'b0);
    tick();
    idle(8);

    // Starvation: both held; expect CCCCD CCCCD with DMA done at cycles 24 and 49
    bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b0; bus0.cpu_addr = 32'h30;
    bus0.dma_req = 1'b1; bus0.dma_we = 1'b0; bus0.dma_addr = 32'h34;
    evt = '0; ne = 0; first_ack = -1; acks = 0;
    for (int k = 0; k < 50; k++) begin
      smp();
      if (bus0.dma_ack) begin
        if (ne < 10) evt[ne] = 1'b1;
        ne++;
        acks++;
        if (first_ack < 0) first_ack = k;
      end else if (!bus0.cpu_stall) begin
        if (ne < 10) evt[ne] = 1'b0;
        ne++;
      end
      tick();
    end
    chk("starve_events", 32'(ne), 32'd10);
    chk("starve_order", {22'd0, evt}, 32'b10_0001_0000);
    chk("starve_acks", 32'(acks), 32'd2);
    chk("starve_first_ack", 32'(first_ack), 32'd24);
    smp();
    chk("starve_cpu_rdata", bus0.cpu_rdata, gmem['h30]);
    chk("starve_dma_rdata", bus0.dma_rdata, gmem['h34]);
    tick();
    idle(8);

    // DMA read withdrawn during WAIT
    bus0.dma_req = 1'b1; bus0.dma_we = 1'b0; bus0.dma_addr = 32'h80;
    tick(); smp();
    chk1("wd_c1_en", bus0.mem_en, 1'b1);
    tick();
    bus0.dma_req = 1'b0;
    tick(); smp();
    chk1("wd_c3_ack", bus0.dma_ack, 1'b0);
    chk1("l1_wd_c3_ack", bus1.dma_ack, 1'b1);
    chk("l1_wd_c3_rdata", bus1.dma_rdata, 32'hDEAD_BEEF);
    tick(); smp();
    chk1("wd_c4_ack", bus0.dma_ack, 1'b1);
    chk("wd_c4_rdata", bus0.dma_rdata, 32'hDEAD_BEEF);
    tick();
    en_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      smp();
      if (bus0.mem_en) en_cnt++;
      tick();
    end
    chk("wd_no_more_en", 32'(en_cnt), 32'd0);

    // Reset during WAIT of a CPU read
    bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b0; bus0.cpu_addr = 32'h44;
    tick(); tick();
    rst = 1'b1;
    bus0.cpu_req = 1'b0;
    tick();
    rst = 1'b0;
    smp();
    chk1("rr_mem_en", bus0.mem_en, 1'b0);
    chk1("rr_mem_we", bus0.mem_we, 1'b0);
    chk1("rr_dma_ack", bus0.dma_ack, 1'b0);
    chk("rr_mem_addr", bus0.mem_addr, 32'h0);
    chk("rr_mem_wdata", bus0.mem_wdata, 32'h0);
    chk("rr_cpu_rdata", bus0.cpu_rdata, 32'h0);
    chk("rr_dma_rdata", bus0.dma_rdata, 32'h0);
    chk1("rr_stall", bus0.cpu_stall, 1'b0);
    chk("l1_rr_cpu_rdata", bus1.cpu_rdata, 32'h0);
    tick(); smp();
    chk1("rr_idle_en", bus0.mem_en, 1'b0);
    tick();

    // Fresh read after reset
    bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b0; bus0.cpu_addr = 32'h40;
    tick(); smp();
    chk1("fr_c1_en", bus0.mem_en, 1'b1);
    tick(); tick(); smp();
    chk1("fr_c3_stall", bus0.cpu_stall, 1'b1);
    tick(); smp();
    chk1("fr_c4_stall", bus0.cpu_stall, 1'b0);
    chk("fr_c4_rdata", bus0.cpu_rdata, 32'h8C01_0004);
    tick();
    idle(8);

    // Random traffic against the transaction-level model (lat-2 instance)
    exp_cpu = 32'h8C01_0004;
    exp_dma = 32'h0;
    cnt_m   = 0;
    for (int n = 0; n < 150; n++) begin
      c = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      bus0.cpu_req = c; bus0.cpu_we = 1'($urandom); bus0.cpu_addr = $urandom;
      bus0.cpu_wdata = $urandom;
      bus0.dma_req = d; bus0.dma_we = 1'($urandom); bus0.dma_addr = $urandom;
      bus0.dma_wdata = $urandom;
      if (!(c || d)) begin
        cnt_m = 0;
        smp();
        chk1("rnd_idle_en", bus0.mem_en, 1'b0);
        chk1("rnd_idle_stall", bus0.cpu_stall, 1'b0);
        tick();
      end else begin
        win_dma = d && (!c || cnt_m == LIM);
        if (win_dma) cnt_m = 0;
        else if (d) cnt_m = (cnt_m == LIM) ? LIM : cnt_m + 1;
        else cnt_m = 0;
        t_we    = win_dma ? bus0.dma_we : bus0.cpu_we;
        t_addr  = win_dma ? bus0.dma_addr : bus0.cpu_addr;
        t_wdata = win_dma ? bus0.dma_wdata : bus0.cpu_wdata;
        t_len   = t_we ? 3 : 3 + LAT0;
        if (t_we) gmem[t_addr[7:0]] = t_wdata;
        else if (win_dma) exp_dma = gmem[t_addr[7:0]];
        else exp_cpu = gmem[t_addr[7:0]];
        for (int k = 0; k < t_len; k++) begin
          smp();
          chk1("rnd_en", bus0.mem_en, k == 1);
          if (k == 1) begin
            chk("rnd_addr", bus0.mem_addr, t_addr);
            chk1("rnd_we", bus0.mem_we, t_we);
            if (t_we) chk("rnd_wdata", bus0.mem_wdata, t_wdata);
          end
          chk1("rnd_ack", bus0.dma_ack, win_dma && k == t_len - 1);
          chk1("rnd_stall", bus0.cpu_stall, c && !(!win_dma && k == t_len - 1));
          if (k == t_len - 1) begin
            chk("rnd_cpu_rdata", bus0.cpu_rdata, exp_cpu);
            chk("rnd_dma_rdata", bus0.dma_rdata, exp_dma);
          end
          tick();
        end
      end
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single unified instruction/data memory of the multicycle MIPS core between the CPU controller and a DMA/loader port. Requests are latched, serialized, and issued to a fixed-latency synchronous memory. The block stalls the CPU controller until its access completes. CPU has priority, and a starvation limit guarantees DMA progress. It sits between the datapath memory-address mux (IorD output) and the memory macro.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory read latency in cycles from mem_en to valid mem_rdata (≥1)
- STARVE_LIM, 4, consecutive CPU grants allowed while DMA is pending (≥1)

- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request, level (MemRead|MemWrite)
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  registered CPU read data
- cpu_stall  out  1  CPU must hold state (gates PCEn/IRWrite/RegWrite upstream)
- dma_req  in  1  DMA request, level
- dma_we  in  1  DMA write enable
- dma_addr  in  ADDR_W  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_rdata  out  DATA_W  registered DMA read data
- dma_ack  out  1  one-cycle completion pulse for DMA
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write, only ever high together with mem_en
- mem_addr  out  ADDR_W  memory address (latched)
- mem_wdata  out  DATA_W  memory write data (latched)
- mem_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Reset → IDLE.
- **IDLE**: if any request is pending, arbitrate and latch the winner's we/addr/wdata and the owner ID, then go to ISSUE. Otherwise stay in IDLE.
- **Arbitration**: CPU wins when both request, unless starve_cnt == STARVE_LIM, in which case DMA wins.
  - starve_cnt increments on each CPU grant made while dma_req = 1.
  - starve_cnt clears on a DMA grant or whenever dma_req = 0. It saturates at STARVE_LIM.
- **ISSUE**: mem_en = 1, mem_we = latched we, mem_addr/mem_wdata driven from latches.
  - Write → DONE.
  - Read → WAIT with lat_cnt = 1.
- **WAIT**:
  - If lat_cnt == MEM_LAT: capture mem_rdata into the owner's rdata register and go to DONE.
  - Otherwise increment lat_cnt.
  - For MEM_LAT = 1, capture happens in the first WAIT cycle.
- **DONE**: completion cycle, then → IDLE unconditionally (one turnaround cycle).
  - DMA owner: dma_ack = 1.
- cpu_stall = cpu_req & ~(state == DONE & owner == CPU). This output is combinational.
- Requester inputs are sampled only at arbitration. Changes mid-access are ignored.
- Request dropped mid-access: the access still completes, rdata is still updated, and dma_ack still pulses.
- A requester holding its request through DONE is re-arbitrated in the following IDLE as a new access.
- cpu_rdata/dma_rdata hold their value until the next read completion for that owner. Writes never change them.
- Reset mid-access: next state IDLE, no mem_en, no ack, no rdata update; lat_cnt and starve_cnt cleared.

## Timing
- **Reset values**: mem_en, mem_we, dma_ack = 0; mem_addr, mem_wdata, cpu_rdata, dma_rdata = 0. cpu_stall = cpu_req (state is IDLE).
- **Read**: request seen in IDLE at cycle 0, mem_en at cycle 1, rdata captured at end of cycle 1+MEM_LAT, DONE at cycle 2+MEM_LAT.
  - With MEM_LAT = 2, the CPU sees stall high in cycles 0–3 and low in cycle 4.
- **Write**: mem_en at cycle 1, DONE at cycle 2.
- **Throughput**: back-to-back reads occupy 3+MEM_LAT cycles each; writes occupy 3.
- mem_en is high in exactly one cycle per access. There is never more than one outstanding access.

## Test plan
- **CPU read**, MEM_LAT = 2, cpu_addr = 0x40, memory returns 0x8C010004: mem_en only in cycle 1; cpu_stall high in cycles 0–3, low in cycle 4; cpu_rdata = 0x8C010004 from cycle 4.
- **Simultaneous**: cpu_req and dma_req both asserted at cycle 0, both writes. CPU is issued first (mem_addr = cpu_addr in cycle 1). DMA is issued in cycle 4, and dma_ack pulses in cycle 5.
- **Starvation**: STARVE_LIM = 4, cpu_req held high, dma_req held high. Four CPU accesses complete, then the fifth grant goes to DMA with dma_ack exactly once; starve_cnt is back to 0 afterwards.
- **Withdrawal**: dma_req dropped during WAIT of a DMA read returning 0xDEADBEEF. dma_ack still pulses and dma_rdata = 0xDEADBEEF; no further mem_en follows.
- **Reset mid-read**: rst = 1 during WAIT. Next cycle IDLE with all outputs at reset values, no ack, and cpu_rdata = 0. A fresh read after reset completes normally.
- **MEM_LAT = 1 read**: DONE occurs at cycle 3. Verify mem_we never asserts without mem_en across random traffic.
